coin_change_dispenser: RTL

//  Downstream stage of the vending FSM. It takes the change amount (cents)

---
 rtl/coin_change_dispenser.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/coin_change_dispenser.sv
// Pays out a latched change amount as coins, largest denomination first,
// over a req/ack handshake to the coin hopper.
module coin_change_dispenser #(
  parameter int unsigned W           = 32,
  parameter int unsigned MAX_CHANGE  = 500,
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] change_in,
  input  logic         ack,
  output logic         coin_req,
  output logic [1:0]   coin_type,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [W-1:0] remaining,
  output logic [7:0]   coin_count
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned ACK_W    = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam int unsigned ACK_LAST = (ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_REQ,
    S_GAP,
    S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic               coin_req_nxt;
  logic [1:0]         coin_type_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic               err_nxt;
  logic [W-1:0]       remaining_nxt;
  logic [CNT_W-1:0]   coin_count_nxt;
  logic [GAP_W-1:0]   gap_cnt, gap_cnt_nxt;
  logic [ACK_W-1:0]   wait_cnt, wait_cnt_nxt;

  // Cent value of a coin code.
  function automatic logic [W-1:0] coin_value(input logic [1:0] t);
    logic [W-1:0] v;
    case (t)
      2'd3:    v = W'(100);
      2'd2:    v = W'(25);
      2'd1:    v = W'(10);
      default: v = W'(5);
    endcase
    return v;
  endfunction

  // Greedy choice of the largest coin that still fits.
  logic       sel_valid;
  logic [1:0] sel_type;

  always_comb begin
    sel_valid = 1'b1;
    sel_type  = 2'd0;
    if (remaining >= W'(100)) begin
      sel_type = 2'd3;
    end else if (remaining >= W'(25)) begin
      sel_type = 2'd2;
    end else if (remaining >= W'(10)) begin
      sel_type = 2'd1;
    end else if (remaining >= W'(5)) begin
      sel_type = 2'd0;
    end else begin
      sel_valid = 1'b0;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt      = state;
    coin_req_nxt   = coin_req;
    coin_type_nxt  = coin_type;
    busy_nxt       = busy;
    done_nxt       = 1'b0;
    err_nxt        = err;
    remaining_nxt  = remaining;
    coin_count_nxt = coin_count;
    gap_cnt_nxt    = gap_cnt;
    wait_cnt_nxt   = wait_cnt;

    case (state)
      S_IDLE: begin
        if (start) begin
          remaining_nxt  = change_in;
          coin_count_nxt = '0;
          busy_nxt       = 1'b1;
          if (change_in > W'(MAX_CHANGE)) begin
            err_nxt   = 1'b1;
            done_nxt  = 1'b1;
            state_nxt = S_DONE;
          end else begin
            err_nxt   = 1'b0;
            state_nxt = S_SELECT;
          end
        end
      end

      S_SELECT: begin
        if (sel_valid) begin
          coin_type_nxt = sel_type;
          coin_req_nxt  = 1'b1;
          wait_cnt_nxt  = '0;
          state_nxt     = S_REQ;
        end else begin
          // A sub-nickel residue cannot be paid and is flagged.
          err_nxt   = (remaining != '0);
          done_nxt  = 1'b1;
          state_nxt = S_DONE;
        end
      end

      S_REQ: begin
        if (ack) begin
          remaining_nxt = remaining - coin_value(coin_type);
          if (coin_count != {CNT_W{1'b1}}) begin
            coin_count_nxt = coin_count + CNT_W'(1);
          end
          coin_req_nxt = 1'b0;
          gap_cnt_nxt  = '0;
          state_nxt    = (GAP_CYCLES > 0) ? S_GAP : S_SELECT;
        end else if (wait_cnt == ACK_W'(ACK_LAST)) begin
          err_nxt      = 1'b1;
          coin_req_nxt = 1'b0;
          done_nxt     = 1'b1;
          state_nxt    = S_DONE;
        end else begin
          wait_cnt_nxt = wait_cnt + ACK_W'(1);
        end
      end

      S_GAP: begin
        if (gap_cnt == GAP_W'(GAP_LAST)) begin
          state_nxt = S_SELECT;
        end else begin
          gap_cnt_nxt = gap_cnt + GAP_W'(1);
        end
      end

      S_DONE: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt    = S_IDLE;
        coin_req_nxt = 1'b0;
        busy_nxt     = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      coin_req   <= 1'b0;
      coin_type  <= 2'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      remaining  <= '0;
      coin_count <= '0;
      gap_cnt    <= '0;
      wait_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      coin_req   <= coin_req_nxt;
      coin_type  <= coin_type_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      remaining  <= remaining_nxt;
      coin_count <= coin_count_nxt;
      gap_cnt    <= gap_cnt_nxt;
      wait_cnt   <= wait_cnt_nxt;
    end
  end

endmodule
